// File: rtl/ctrl_pkg.sv
// Shared encodings for the control sequencer: FSM states, opcode fields,
// decoded operation classes and ALU one-hot bit positions.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_DECODE   = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_LITERAL  = 3'd4,
        S_HALT     = 3'd5,
        S_TRAP     = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        OP_ILLEGAL = 4'd0,
        OP_ALU3    = 4'd1,
        OP_MOV     = 4'd2,
        OP_CMP     = 4'd3,
        OP_JMP     = 4'd4,
        OP_LDM     = 4'd5,
        OP_STM     = 4'd6,
        OP_NEG     = 4'd7,
        OP_LDL     = 4'd8,
        OP_GTF     = 4'd9,
        OP_STF     = 4'd10,
        OP_NOP     = 4'd11,
        OP_HALT    = 4'd12
    } op_t;

    localparam int ALU_W    = 9;
    localparam int ALU_PASS = 0;
    localparam int ALU_ADD  = 1;
    localparam int ALU_SUB  = 2;
    localparam int ALU_SHR  = 3;
    localparam int ALU_SHL  = 4;
    localparam int ALU_AND  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_NEG  = 8;

    // Primary opcode field [15:12]
    localparam logic [3:0] OPC_ADD = 4'h1;
    localparam logic [3:0] OPC_SUB = 4'h2;
    localparam logic [3:0] OPC_AND = 4'h3;
    localparam logic [3:0] OPC_OR  = 4'h4;
    localparam logic [3:0] OPC_XOR = 4'h5;
    localparam logic [3:0] OPC_SHR = 4'h6;
    localparam logic [3:0] OPC_SHL = 4'h7;
    localparam logic [3:0] OPC_EXT = 4'hF;

    // Two-operand sub-opcode field [11:8]
    localparam logic [3:0] SUB_MOV = 4'h1;
    localparam logic [3:0] SUB_CMP = 4'h2;
    localparam logic [3:0] SUB_JMP = 4'h3;
    localparam logic [3:0] SUB_LDM = 4'h4;
    localparam logic [3:0] SUB_STM = 4'h5;
    localparam logic [3:0] SUB_NEG = 4'h6;

    // One-operand sub-opcode field [7:4]
    localparam logic [3:0] UNI_LDL = 4'h1;
    localparam logic [3:0] UNI_GTF = 4'h2;
    localparam logic [3:0] UNI_STF = 4'h3;

    localparam logic [15:0] INSTR_NOP  = 16'hFFFF;
    localparam logic [15:0] INSTR_HALT = 16'hFFF0;

    function automatic logic [ALU_W-1:0] alu_onehot(input int idx);
        return ALU_W'(1) << idx;
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Purely combinational instruction classifier: maps a 16-bit instruction
// to an operation class and, for ALU-using operations, a one-hot alu_op.
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [15:0]      i_instr,
    output op_t              o_op,
    output logic [ALU_W-1:0] o_alu
);

    always_comb begin
        o_op  = OP_ILLEGAL;
        o_alu = '0;
        case (i_instr[15:12])
            OPC_ADD: begin o_op = OP_ALU3; o_alu = alu_onehot(ALU_ADD); end
            OPC_SUB: begin o_op = OP_ALU3; o_alu = alu_onehot(ALU_SUB); end
            OPC_AND: begin o_op = OP_ALU3; o_alu = alu_onehot(ALU_AND); end
            OPC_OR:  begin o_op = OP_ALU3; o_alu = alu_onehot(ALU_OR);  end
            OPC_XOR: begin o_op = OP_ALU3; o_alu = alu_onehot(ALU_XOR); end
            OPC_SHR: begin o_op = OP_ALU3; o_alu = alu_onehot(ALU_SHR); end
            OPC_SHL: begin o_op = OP_ALU3; o_alu = alu_onehot(ALU_SHL); end
            OPC_EXT: begin
                // Exact 0-op encodings take priority over the FF-prefixed 1-op space
                if (i_instr == INSTR_NOP) begin
                    o_op = OP_NOP;
                end else if (i_instr == INSTR_HALT) begin
                    o_op = OP_HALT;
                end else if (i_instr[11:8] == 4'hF) begin
                    case (i_instr[7:4])
                        UNI_LDL: o_op = OP_LDL;
                        UNI_GTF: o_op = OP_GTF;
                        UNI_STF: o_op = OP_STF;
                        default: o_op = OP_ILLEGAL;
                    endcase
                end else begin
                    case (i_instr[11:8])
                        SUB_MOV: begin o_op = OP_MOV; o_alu = alu_onehot(ALU_PASS); end
                        SUB_CMP: o_op = OP_CMP;
                        SUB_JMP: o_op = OP_JMP;
                        SUB_LDM: o_op = OP_LDM;
                        SUB_STM: o_op = OP_STM;
                        SUB_NEG: begin o_op = OP_NEG; o_alu = alu_onehot(ALU_NEG); end
                        default: o_op = OP_ILLEGAL;
                    endcase
                end
            end
            default: o_op = OP_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch/decode FSM driving register file,
// ALU, compare unit and memory handshake. Define CTRL_TRAP_EN to trap on illegal opcodes.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int          DATA_W      = 16,
    parameter int          MEM_TIMEOUT = 15,
    parameter logic [15:0] TRAP_VECTOR = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DATA_W-1:0] i_bus,
    input  logic [DATA_W-1:0] flags,
    output logic [DATA_W-1:0] d_bus,
    output logic              d_oe,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              mem_ready,
    output logic              pc_increment,
    output logic              pc_load,
    output logic              cmp_load,
    output logic              cmp_compare,
    output logic [ALU_W-1:0]  alu_op,
    output logic              reg1_read,
    output logic              reg2_read,
    output logic              reg3_write,
    output logic [3:0]        reg1_addr,
    output logic [3:0]        reg2_addr,
    output logic [3:0]        reg3_addr,
    output logic              halted,
    output logic              bus_err,
    output logic              trap
);

    localparam logic [7:0] LP_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_ir;
    logic [7:0]       r_wait;
    logic             r_bus_err;
    logic [3:0]       r_reg1_addr, r_reg2_addr, r_reg3_addr;
    op_t              w_op;
    logic [ALU_W-1:0] w_alu;
    logic [3:0]       w_a1, w_a2, w_a3;
    logic             w_is_ldm;
    logic             w_timeout;

    ctrl_decoder u_decoder (
        .i_instr (r_ir),
        .o_op    (w_op),
        .o_alu   (w_alu)
    );

    // Operand fields shift right as the opcode space narrows (3-op, 2-op, 1-op)
    assign w_a1 = (r_ir[15:8] == 8'hFF)     ? r_ir[3:0] :
                  (r_ir[15:12] == OPC_EXT)  ? r_ir[7:4] : r_ir[11:8];
    assign w_a2 = (r_ir[15:12] == OPC_EXT)  ? r_ir[3:0] : r_ir[7:4];
    assign w_a3 = r_ir[3:0];

    assign w_is_ldm  = (r_ir[11:8] == SUB_LDM);
    assign w_timeout = (r_state == S_MEM_WAIT) && !mem_ready && (r_wait == LP_WAIT_LAST);
    assign bus_err   = r_bus_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ir        <= '0;
            r_wait      <= '0;
            r_bus_err   <= 1'b0;
            r_reg1_addr <= '0;
            r_reg2_addr <= '0;
            r_reg3_addr <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH) r_ir <= i_bus[15:0];
            // Counter idles at zero so it is already clear on every MEM_WAIT entry
            if (r_state == S_MEM_WAIT) r_wait <= r_wait + 8'd1;
            else                       r_wait <= '0;
            if (w_timeout) r_bus_err <= 1'b1;
            r_reg1_addr <= reg1_addr;
            r_reg2_addr <= reg2_addr;
            r_reg3_addr <= reg3_addr;
        end
    end

    always_comb begin
        w_next       = r_state;
        d_bus        = '0;
        d_oe         = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        pc_increment = 1'b0;
        pc_load      = 1'b0;
        cmp_load     = 1'b0;
        cmp_compare  = 1'b0;
        alu_op       = '0;
        reg1_read    = 1'b0;
        reg2_read    = 1'b0;
        reg3_write   = 1'b0;
        reg1_addr    = r_reg1_addr;
        reg2_addr    = r_reg2_addr;
        reg3_addr    = r_reg3_addr;
        halted       = 1'b0;
        trap         = 1'b0;
        case (r_state)
            S_IDLE:  if (run) w_next = S_FETCH;
            S_FETCH: begin
                pc_increment = 1'b1;
                w_next       = S_DECODE;
            end
            S_DECODE: begin
                w_next = S_FETCH;
                case (w_op)
                    OP_ALU3: begin
                        reg1_addr = w_a1; reg2_addr = w_a2; reg3_addr = w_a3;
                        reg1_read = 1'b1; reg2_read = 1'b1; reg3_write = 1'b1;
                        alu_op    = w_alu;
                    end
                    OP_MOV, OP_NEG: begin
                        reg1_addr = w_a1; reg2_addr = w_a2; reg3_addr = w_a3;
                        reg1_read = 1'b1; reg3_write = 1'b1;
                        alu_op    = w_alu;
                    end
                    OP_CMP: begin
                        reg1_addr = w_a1; reg2_addr = w_a2; reg3_addr = w_a3;
                        reg1_read = 1'b1; reg2_read = 1'b1; cmp_compare = 1'b1;
                    end
                    OP_JMP: begin
                        reg1_addr = w_a1; reg2_addr = w_a2; reg3_addr = w_a3;
                        reg1_read = 1'b1; pc_load = 1'b1;
                    end
                    OP_LDM, OP_STM: begin
                        reg1_addr = w_a1; reg2_addr = w_a2; reg3_addr = w_a3;
                        reg1_read = 1'b1;
                        reg2_read = (w_op == OP_STM);
                        w_next    = S_MEM_WAIT;
                    end
                    OP_LDL: begin
                        reg3_addr    = w_a3;
                        pc_increment = 1'b1;
                        w_next       = S_LITERAL;
                    end
                    OP_GTF: begin
                        reg3_addr  = w_a3;
                        d_bus      = flags;
                        d_oe       = 1'b1;
                        reg3_write = 1'b1;
                    end
                    OP_STF: begin
                        reg1_addr = w_a1;
                        reg1_read = 1'b1;
                        cmp_load  = 1'b1;
                    end
                    OP_NOP:  w_next = S_FETCH;
                    OP_HALT: w_next = S_HALT;
                    default: begin
`ifdef CTRL_TRAP_EN
                        w_next = S_TRAP;
`else
                        w_next = S_HALT;
`endif
                    end
                endcase
            end
            S_MEM_WAIT: begin
                mem_read  = w_is_ldm;
                mem_write = !w_is_ldm;
                if (mem_ready) begin
                    reg3_write = w_is_ldm;
                    w_next     = S_FETCH;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_LITERAL: begin
                d_bus      = i_bus;
                d_oe       = 1'b1;
                reg3_write = 1'b1;
                w_next     = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (!run) w_next = S_IDLE;
            end
            S_TRAP: begin
`ifdef CTRL_TRAP_EN
                trap = 1'b1;
`endif
                d_bus   = DATA_W'(TRAP_VECTOR);
                d_oe    = 1'b1;
                pc_load = 1'b1;
                w_next  = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer (build with CTRL_TRAP_EN
// defined to exercise the trap path).
module tb_control_sequencer;

    localparam logic [15:0] TV = 16'h0040;

    localparam logic [20:0] PCI = 21'h1 << 20;
    localparam logic [20:0] PCL = 21'h1 << 19;
    localparam logic [20:0] CML = 21'h1 << 18;
    localparam logic [20:0] CMC = 21'h1 << 17;
    localparam logic [20:0] R1  = 21'h1 << 16;
    localparam logic [20:0] R2  = 21'h1 << 15;
    localparam logic [20:0] W3  = 21'h1 << 14;
    localparam logic [20:0] DOE = 21'h1 << 13;
    localparam logic [20:0] MR  = 21'h1 << 12;
    localparam logic [20:0] MW  = 21'h1 << 11;
    localparam logic [20:0] HLT = 21'h1 << 10;
    localparam logic [20:0] TRP = 21'h1 << 9;

    logic        clk = 1'b0;
    logic        rst, run, mem_ready;
    logic [15:0] i_bus, flags, d_bus;
    logic        d_oe, mem_read, mem_write;
    logic        pc_increment, pc_load, cmp_load, cmp_compare;
    logic [8:0]  alu_op;
    logic        reg1_read, reg2_read, reg3_write;
    logic [3:0]  reg1_addr, reg2_addr, reg3_addr;
    logic        halted, bus_err, trap;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] instr;
        logic [20:0] ctl;
        logic [3:0]  a1, a2, a3;
        logic        chk_addr;
    } vec_t;

    vec_t vecs[14];

    control_sequencer #(.DATA_W(16), .MEM_TIMEOUT(15), .TRAP_VECTOR(TV)) dut (
        .clk(clk), .rst(rst), .run(run), .i_bus(i_bus), .flags(flags),
        .d_bus(d_bus), .d_oe(d_oe), .mem_read(mem_read), .mem_write(mem_write),
        .mem_ready(mem_ready), .pc_increment(pc_increment), .pc_load(pc_load),
        .cmp_load(cmp_load), .cmp_compare(cmp_compare), .alu_op(alu_op),
        .reg1_read(reg1_read), .reg2_read(reg2_read), .reg3_write(reg3_write),
        .reg1_addr(reg1_addr), .reg2_addr(reg2_addr), .reg3_addr(reg3_addr),
        .halted(halted), .bus_err(bus_err), .trap(trap)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] obs();
        return {pc_increment, pc_load, cmp_load, cmp_compare, reg1_read, reg2_read,
                reg3_write, d_oe, mem_read, mem_write, halted, trap, alu_op};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic fetch(input logic [15:0] instr);
        @(negedge clk);
        i_bus = instr;
        #1;
        chk($sformatf("fetch_%h", instr), obs(), PCI);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        vecs[0]  = '{16'h1123, R1|R2|W3|21'h002, 4'h1, 4'h2, 4'h3, 1'b1};
        vecs[1]  = '{16'h2456, R1|R2|W3|21'h004, 4'h4, 4'h5, 4'h6, 1'b1};
        vecs[2]  = '{16'h3789, R1|R2|W3|21'h020, 4'h7, 4'h8, 4'h9, 1'b1};
        vecs[3]  = '{16'h4ABC, R1|R2|W3|21'h040, 4'hA, 4'hB, 4'hC, 1'b1};
        vecs[4]  = '{16'h5DEF, R1|R2|W3|21'h080, 4'hD, 4'hE, 4'hF, 1'b1};
        vecs[5]  = '{16'h6010, R1|R2|W3|21'h008, 4'h0, 4'h1, 4'h0, 1'b1};
        vecs[6]  = '{16'h7321, R1|R2|W3|21'h010, 4'h3, 4'h2, 4'h1, 1'b1};
        vecs[7]  = '{16'hF1A7, R1|W3|21'h001,    4'hA, 4'h7, 4'h7, 1'b1};
        vecs[8]  = '{16'hF6B4, R1|W3|21'h100,    4'hB, 4'h4, 4'h4, 1'b1};
        vecs[9]  = '{16'hF2C5, R1|R2|CMC,        4'hC, 4'h5, 4'h5, 1'b1};
        vecs[10] = '{16'hF3D0, R1|PCL,           4'hD, 4'h0, 4'h0, 1'b1};
        vecs[11] = '{16'hFFFF, 21'h0,            4'hD, 4'h0, 4'h0, 1'b1};
        vecs[12] = '{16'hFF29, DOE|W3,           4'h0, 4'h0, 4'h0, 1'b0};
        vecs[13] = '{16'hFF3B, R1|CML,           4'h0, 4'h0, 4'h0, 1'b0};

        rst = 1'b1; run = 1'b0; mem_ready = 1'b0; i_bus = '0; flags = 16'hA5C3;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctl", obs(), 21'h0);
        chk("reset_dbus", d_bus, 16'h0);
        chk("reset_addr", {reg1_addr, reg2_addr, reg3_addr, bus_err}, 13'h0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("idle_run0", obs(), 21'h0);
        run = 1'b1;

        for (int i = 0; i < 14; i++) begin
            fetch(vecs[i].instr);
            @(negedge clk); #1;
            chk($sformatf("decode_%h", vecs[i].instr), obs(), vecs[i].ctl);
            if (vecs[i].chk_addr)
                chk($sformatf("addr_%h", vecs[i].instr), {reg1_addr, reg2_addr, reg3_addr},
                    {vecs[i].a1, vecs[i].a2, vecs[i].a3});
            if (vecs[i].ctl & DOE)
                chk($sformatf("dbus_%h", vecs[i].instr), d_bus, flags);
        end

        // ldl followed by literal word
        fetch(16'hFF15);
        @(negedge clk); #1;
        chk("ldl_decode", obs(), PCI);
        chk("ldl_r3addr", reg3_addr, 4'h5);
        @(negedge clk); i_bus = 16'hBEEF; #1;
        chk("literal_ctl", obs(), W3|DOE);
        chk("literal_dbus", d_bus, 16'hBEEF);
        chk("literal_r3addr", reg3_addr, 4'h5);

        // ldm with mem_ready after three wait cycles; stray mem_ready before is ignored
        mem_ready = 1'b1;
        fetch(16'hF423);
        @(negedge clk); #1;
        chk("ldm_decode", obs(), R1);
        chk("ldm_r1addr", reg1_addr, 4'h2);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ready = (i == 3);
            #1;
            if (mem_read) cnt++;
            if (i == 3) begin
                chk("ldm_ready_ctl", obs(), MR|W3);
                chk("ldm_r3addr", reg3_addr, 4'h3);
            end
        end
        chk("ldm_read_cycles", cnt, 4);

        // stm with mem_ready never arriving
        fetch(16'hF512);
        @(negedge clk); #1;
        chk("stm_decode", obs(), R1|R2);
        chk("stm_addr", {reg1_addr, reg2_addr}, 8'h12);
        mem_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (halted) break;
            if (mem_write) cnt++;
        end
        chk("stm_write_cycles", cnt, 15);
        chk("stm_timeout_ctl", obs(), HLT);
        chk("stm_bus_err", bus_err, 1'b1);
        @(negedge clk); #1;
        chk("halt_hold", obs(), HLT);
        run = 1'b0;
        @(negedge clk); #1;
        chk("halt_to_idle", obs(), 21'h0);
        chk("bus_err_sticky", bus_err, 1'b1);
        run = 1'b1;

        // explicit halt instruction
        fetch(16'hFFF0);
        @(negedge clk); #1;
        chk("halt_decode", obs(), 21'h0);
        @(negedge clk); #1;
        chk("halt_state", obs(), HLT);
        run = 1'b0;
        @(negedge clk); #1;
        chk("halt_idle", obs(), 21'h0);
        run = 1'b1;

        // illegal opcode
        fetch(16'hE000);
        @(negedge clk); #1;
        chk("illegal_decode", obs(), 21'h0);
        @(negedge clk); #1;
`ifdef CTRL_TRAP_EN
        chk("trap_ctl", obs(), PCL|DOE|TRP);
        chk("trap_dbus", d_bus, TV);
`else
        chk("illegal_halt", obs(), HLT);
        run = 1'b0;
        @(negedge clk); #1;
        chk("illegal_idle", obs(), 21'h0);
        run = 1'b1;
`endif

        // asynchronous reset in the middle of a memory wait
        fetch(16'hF423);
        @(negedge clk); #1;
        chk("ldm2_decode", obs(), R1);
        @(negedge clk); mem_ready = 1'b0; #1;
        chk("ldm2_wait", obs(), MR);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ctl", obs(), 21'h0);
        chk("async_rst_misc", {d_bus, reg1_addr, reg2_addr, reg3_addr, bus_err}, 29'h0);
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("post_rst_idle", obs(), 21'h0);
        run = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_fetch", obs(), PCI);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16: bus/instruction width, legal range 16..64; instruction fields come from bits [15:0], and upper bits are ignored.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15: maximum wait cycles for mem_ready, legal range 1..255.
REQ-003 SHALL have parameter TRAP_VECTOR, default 16'h0000: PC load value on a trap (used only with CTRL_TRAP_EN).
REQ-004 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port run  in  1  level; starts execution from IDLE.
REQ-007 SHALL have ports i_bus  in  DATA_W  instruction/literal word, and flags  in  DATA_W  compare flags.
REQ-008 SHALL have ports d_bus  out  DATA_W  data driven to the datapath, and d_oe  out  1  d_bus valid (no tristate).
REQ-009 SHALL have ports mem_read, mem_write  out  1; mem_ready  in  1  memory handshake.
REQ-010 SHALL have ports pc_increment, pc_load, cmp_load, cmp_compare  out  1  single-cycle strobes.
REQ-011 SHALL have port alu_op  out  9  one-hot {negate,xor,or,and,shl,shr,sub,add,pass}, or all-zero.
REQ-012 SHALL have ports reg1_read, reg2_read, reg3_write  out  1; reg1_addr, reg2_addr, reg3_addr  out  4.
REQ-013 SHALL have ports halted  out  1  in HALT; bus_err  out  1  sticky memory-timeout flag; trap  out  1  one-cycle pulse.

Function
REQ-014 SHALL implement states IDLE, FETCH, DECODE, MEM_WAIT, LITERAL, HALT, TRAP (TRAP only with CTRL_TRAP_EN).
REQ-015 SHALL deassert every strobe, alu_op and d_oe each cycle unless the current state asserts them; register addresses hold their last value.
REQ-016 IDLE: SHALL move to FETCH when run=1, else remain in IDLE.
REQ-017 FETCH: SHALL latch i_bus into the instruction register, pulse pc_increment, and go to DECODE.
REQ-018 DECODE, 3-op (opcode [15:12] = 1..7 add/sub/and/or/xor/shr/shl): SHALL set reg1/reg2/reg3 addr = [11:8]/[7:4]/[3:0], assert both reads, the matching alu_op and reg3_write, then go to FETCH.
REQ-019 DECODE, 2-op ([15:12]=F; [11:8] = mov 1, cmp 2, jmp 3, ldm 4, stm 5, neg 6): SHALL use reg1_addr=[7:4] and reg2/reg3_addr=[3:0].
REQ-020 mov and neg SHALL assert reg1_read, alu_op pass or negate, and reg3_write; cmp SHALL assert both reads and cmp_compare; jmp SHALL assert reg1_read and pc_load.
REQ-021 ldm and stm SHALL assert reg1_read (address) and go to MEM_WAIT; stm also asserts reg2_read (data).
REQ-022 MEM_WAIT: SHALL hold mem_read (ldm) or mem_write (stm) until mem_ready=1; on that cycle ldm asserts reg3_write, then the state goes to FETCH.
REQ-023 A wait counter SHALL clear on entry to MEM_WAIT; if MEM_TIMEOUT cycles elapse without mem_ready, the block SHALL set bus_err, drop the request, and go to HALT.
REQ-024 DECODE, 1-op ([15:8]=FF; [7:4] = ldl 1, gtf 2, stf 3): ldl SHALL pulse pc_increment, set reg3_addr=[3:0], and go to LITERAL.
REQ-025 gtf SHALL drive d_bus=flags with d_oe and reg3_write; stf SHALL assert reg1_read and cmp_load; both return to FETCH.
REQ-026 LITERAL: SHALL drive d_bus=i_bus with d_oe, assert reg3_write, and go to FETCH.
REQ-027 0-op: FFFF (nop) SHALL go to FETCH; FFF0 (halt) SHALL go to HALT.
REQ-028 Any other encoding SHALL be illegal.
REQ-029 HALT: SHALL assert halted and go to IDLE only when run=0.
REQ-030 mem_ready SHALL be ignored outside MEM_WAIT.

Reset
REQ-031 While rst=1, the block SHALL be in IDLE with all outputs 0, instruction register 0, wait counter 0, and bus_err 0, including when reset hits mid-MEM_WAIT; the request drops immediately.

Configuration
REQ-032 With CTRL_TRAP_EN defined, an illegal opcode SHALL enter TRAP: pulse trap, drive d_bus=TRAP_VECTOR with d_oe and pc_load, then go to FETCH.
REQ-033 Without CTRL_TRAP_EN, an illegal opcode SHALL go to HALT, and trap SHALL be tied to 0.

Structure
REQ-034 Opcode constants, state encoding and alu_op bit indices SHALL live in package ctrl_pkg.
REQ-035 Combinational instruction decoding SHALL be a sub-module ctrl_decoder, instantiated once.

Verification
REQ-036 Reset, run=1, i_bus=16'h1123 -> pc_increment in cycle 1, then reads r1/r2, alu_op=add, reg3_write to r3 in cycle 2.
REQ-037 i_bus=16'hFF15, then literal 16'hBEEF -> two pc_increment pulses; d_bus=16'hBEEF with d_oe and reg3_write to r5 in LITERAL.
REQ-038 ldm 16'hF423, mem_ready after 3 cycles -> mem_read high exactly 4 cycles, then reg3_write to r3.
REQ-039 stm, mem_ready held low, MEM_TIMEOUT=15 -> mem_write drops after 15 cycles, bus_err=1, halted=1.
REQ-040 i_bus=16'hE000 -> HALT without CTRL_TRAP_EN; with it, trap pulse, pc_load with d_bus=TRAP_VECTOR, then FETCH.
REQ-041 rst asserted mid-MEM_WAIT -> all outputs 0 asynchronously; after release, IDLE until run=1.
